// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// The optional frame timeout is enabled by PS2_KBD_FRAME_TIMEOUT_EN.
package ps2_kbd_pkg;

  localparam int unsigned START      = 0;
  localparam int unsigned DATA_LSB   = 1;
  localparam int unsigned PARITY     = 9;
  localparam int unsigned STOP       = 10;
  localparam int unsigned FRAME_BITS = 11;

  localparam logic [15:0] IDLE_TIMEOUT = 16'hFFFF;

  typedef logic [7:0] scan_code_t;

  // Start low, stop high and odd parity across data plus parity bit.
  function automatic logic frame_ok(input logic [FRAME_BITS-2:0] bits, input logic stop_bit);
    return ~bits[START] & stop_bit & (^bits[PARITY:DATA_LSB]);
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Bus bundle between the PS/2 pins/consumer side and the keyboard receiver.
// Signal names follow the board-level pin and consumer naming.
interface ps2_keyboard_rx_if;
  import ps2_kbd_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  scan_code_t data;
  logic       ready;
  logic       overflow;

  modport master (
    output ps2_clk, ps2_data, nextdata_n,
    input  data, ready, overflow
  );

  modport slave (
    input  ps2_clk, ps2_data, nextdata_n,
    output data, ready, overflow
  );

endinterface

// File: rtl/ps2_keyboard_rx_fifo.sv
// Synchronous scan-code FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart by occupancy.
module ps2_kbd_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push_i,
  input  scan_code_t wdata_i,
  input  logic       pop_i,
  output scan_code_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  scan_code_t  mem_q [DEPTH];
  logic [AW:0] w_ptr_q, w_ptr_d;
  logic [AW:0] r_ptr_q, r_ptr_d;
  logic [AW:0] occupancy;

  assign occupancy = w_ptr_q - r_ptr_q;
  assign full_o    = (occupancy == DEPTH_V);
  assign empty_o   = (occupancy == '0);
  assign rdata_o   = mem_q[r_ptr_q[AW-1:0]];

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (push_i && !full_o) w_ptr_d = w_ptr_q + 1'b1;
    if (pop_i && !empty_o) r_ptr_d = r_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[w_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames
// and queues valid scan codes. Optional timeout: PS2_KBD_FRAME_TIMEOUT_EN.
module ps2_keyboard_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input logic               clk,
  input logic               clrn,
  ps2_keyboard_rx_if.slave  bus
);

  localparam logic [3:0] LAST_BIT = 4'(STOP);

  logic [SYNC_STAGES-1:0]  clk_sync_q;
  logic [SYNC_STAGES-1:0]  data_sync_q;
  logic                    sample_en;
  logic                    rx_bit;

  logic [3:0]              cnt_q, cnt_d;
  logic [FRAME_BITS-2:0]   frame_q, frame_d;
  logic                    frame_done;
  logic                    frame_valid;

  logic                    overflow_q, overflow_d;
  scan_code_t              last_q, last_d;

  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  scan_code_t              head;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
    end
  end

  assign sample_en = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign rx_bit    = data_sync_q[SYNC_STAGES-1];

`ifdef PS2_KBD_FRAME_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (sample_en)                  idle_d = '0;
    else if (idle_q != IDLE_TIMEOUT) idle_d = idle_q + 16'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  // Bits land at their frame position; the stop bit is judged as it arrives.
  always_comb begin
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    frame_done = 1'b0;
    if (sample_en) begin
      if (cnt_q == LAST_BIT) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        frame_d[cnt_q] = rx_bit;
        cnt_d          = cnt_q + 4'd1;
      end
    end
`ifdef PS2_KBD_FRAME_TIMEOUT_EN
    else if (idle_q == IDLE_TIMEOUT && cnt_q != '0) begin
      cnt_d = '0;
    end
`endif
  end

  assign frame_valid = frame_done & frame_ok(frame_q, rx_bit);
  assign push        = frame_valid & ~full;
  assign pop         = ~empty & ~bus.nextdata_n;

  always_comb begin
    overflow_d = overflow_q | (frame_valid & full);
    last_d     = pop ? head : last_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q      <= '0;
      frame_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  ps2_kbd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (push),
    .wdata_i (frame_q[PARITY-1:DATA_LSB]),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.ready    = ~empty;
  assign bus.overflow = overflow_q;
  assign bus.data     = empty ? last_q : head;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: sends hand-built PS/2 frames and checks
// ready/data/overflow against hand-computed values.
module tb_ps2_keyboard_rx;

  localparam time BIT_HALF = 200ns;

  logic clk;
  logic clrn;
  int   total;
  int   bad;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(
    .FIFO_DEPTH  (8),
    .SYNC_STAGES (3)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Drives the first nEdges bits of a frame; odd parity unless badParity.
  task automatic applyStimulus(input logic [7:0] code, input logic badParity,
                               input logic stopBit, input int nEdges);
    logic [10:0] bits;
    bits = {stopBit, (~^code) ^ badParity, code, 1'b0};
    for (int i = 0; i < nEdges; i++) begin
      bus.ps2_data = bits[i];
      #BIT_HALF;
      bus.ps2_clk = 1'b0;
      #BIT_HALF;
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    #(2 * BIT_HALF);
    @(negedge clk);
  endtask

  task automatic popOne();
    @(negedge clk);
    bus.nextdata_n = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.ps2_clk    = 1'b1;
    bus.ps2_data   = 1'b1;
    bus.nextdata_n = 1'b1;
    clrn = 1'b0;
    #1;
    checkOutput("rst_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("rst_ovf", {7'd0, bus.overflow}, 8'h00);
    checkOutput("rst_data", bus.data, 8'h00);
    #20;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("1c_ready", {7'd0, bus.ready}, 8'h01);
    checkOutput("1c_data", bus.data, 8'h1C);
    checkOutput("1c_ovf", {7'd0, bus.overflow}, 8'h00);
    popOne();
    checkOutput("pop_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("pop_data", bus.data, 8'h1C);

    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkOutput("two_head", bus.data, 8'hF0);
    popOne();
    checkOutput("two_pop1_ready", {7'd0, bus.ready}, 8'h01);
    checkOutput("two_pop1_data", bus.data, 8'h1C);
    popOne();
    checkOutput("two_pop2_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("two_pop2_data", bus.data, 8'h1C);

    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0, 1'b1, 11);
    checkOutput("full_ovf", {7'd0, bus.overflow}, 8'h00);
    applyStimulus(8'h09, 1'b0, 1'b1, 11);
    checkOutput("drop_ovf", {7'd0, bus.overflow}, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("drain_%0d", i), bus.data, 8'(i));
      popOne();
    end
    checkOutput("drain_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("drain_last", bus.data, 8'h08);

    applyStimulus(8'h1C, 1'b1, 1'b1, 11);
    checkOutput("badpar_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("badpar_data", bus.data, 8'h08);
    applyStimulus(8'h1C, 1'b0, 1'b0, 11);
    checkOutput("badstop_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("badstop_data", bus.data, 8'h08);
    checkOutput("bad_ovf", {7'd0, bus.overflow}, 8'h01);

    applyStimulus(8'h55, 1'b0, 1'b1, 5);
    clrn = 1'b0;
    #1;
    checkOutput("midrst_ready", {7'd0, bus.ready}, 8'h00);
    checkOutput("midrst_ovf", {7'd0, bus.overflow}, 8'h00);
    checkOutput("midrst_data", bus.data, 8'h00);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    applyStimulus(8'h2E, 1'b0, 1'b1, 11);
    checkOutput("2e_ready", {7'd0, bus.ready}, 8'h01);
    checkOutput("2e_data", bus.data, 8'h2E);
    popOne();
    checkOutput("2e_empty", {7'd0, bus.ready}, 8'h00);
    checkOutput("2e_last", bus.data, 8'h2E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
